// File: rtl/ysyx_22040237_ifu_if.sv
// Fetch-unit bundle: instruction-memory req/gnt/rvalid bus, decode valid/ready handshake and
// execute-unit redirect. Signal names keep their direction as seen from the IFU.
//   master : the IFU side (drives imem request, instruction and misalign pulse)
//   slave  : the environment side (memory, decode and execute)
interface ysyx_22040237_ifu_if;
  logic        pc_jump_flag_i;
  logic [63:0] pc_jump_addr_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        fetch_misalign_o;

  modport master (
    input  pc_jump_flag_i, pc_jump_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o, fetch_misalign_o
  );

  modport slave (
    output pc_jump_flag_i, pc_jump_addr_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o, fetch_misalign_o
  );
endinterface

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit. Owns the PC, issues one outstanding imem request at a time and holds
// the fetched instruction for decode until it is accepted or a redirect discards it.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   bus  : ysyx_22040237_ifu_if.master (imem bus, decode handshake, redirect, misalign pulse)
// All outputs come straight from registers or from decoded registered state.
module ysyx_22040237_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22040237_ifu_if.master    bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic        misalign_q, misalign_d;

  logic        jump;
  logic [63:0] jump_target;

  // IDLE only lasts one cycle after reset, so a redirect there is ignored.
  assign jump        = bus.pc_jump_flag_i && (state_q != IDLE);
  assign jump_target = {bus.pc_jump_addr_i[63:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    misalign_d = jump && (bus.pc_jump_addr_i[1:0] != 2'b00);

    if (jump) begin
      pc_d = jump_target;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_gnt_i) begin
          state_d = WAIT;
          // A grant alongside a redirect belongs to the stale address.
          if (jump) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid_i) begin
          if (jump || drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d    = bus.imem_rdata_i;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end else if (jump) begin
          // Already-set drop stays set: still exactly one response outstanding.
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (jump) begin
          state_d = REQ;
        end else if (bus.inst_ready_i) begin
          pc_d    = pc_q + 64'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      inst_q     <= 32'h0;
      inst_pc_q  <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.imem_req_o       = (state_q == REQ);
  assign bus.imem_addr_o      = pc_q;
  assign bus.inst_valid_o     = (state_q == HOLD);
  assign bus.inst_o           = inst_q;
  assign bus.pc_o             = inst_pc_q;
  assign bus.fetch_misalign_o = misalign_q;

endmodule

// File: doc/ysyx_22040237_ifu.md
# ysyx_22040237_ifu

Instruction fetch unit for the ysyx_22040237 core. It owns the PC register and issues one-at-a-time requests to instruction memory over a req/gnt/rvalid interface. It presents each fetched instruction to decode with a valid/ready handshake. It is the receiving end of the execute unit's `pc_jump_flag`/`pc_jump_addr` redirect interface, and discards any in-flight or held instruction when a redirect arrives.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC after reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_jump_flag_i`  in  1  redirect request from execute unit; single-cycle pulse per taken branch or jump.
- `pc_jump_addr_i`  in  64  redirect target.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  64  fetch address, always equal to the current PC.
- `imem_gnt_i`  in  1  memory accepts the request this cycle.
- `imem_rvalid_i`  in  1  response valid; arrives at least 1 cycle after gnt.
- `imem_rdata_i`  in  32  response instruction.
- `inst_valid_o`  out  1  instruction available to decode.
- `inst_ready_i`  in  1  decode accepts the instruction.
- `inst_o`  out  32  held instruction.
- `pc_o`  out  64  PC of `inst_o`.
- `fetch_misalign_o`  out  1  one-cycle pulse: redirect target had addr[1:0] != 0.

## Operation
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE is entered only from reset and moves to REQ unconditionally on the next edge.
- REQ: `imem_req_o`=1 with `imem_addr_o`=PC. On `imem_gnt_i`, go to WAIT.
- WAIT: `imem_req_o`=0. On `imem_rvalid_i`, capture `imem_rdata_i` into `inst_o`, capture PC into `pc_o`, and go to HOLD.
- HOLD: `inst_valid_o`=1. On `inst_valid_o & inst_ready_i`, set PC to PC+4 (64-bit wrap) and go to REQ.
- Redirect (`pc_jump_flag_i`=1) has highest priority in every state except IDLE:
  - PC takes `{pc_jump_addr_i[63:2], 2'b00}`.
  - If `pc_jump_addr_i[1:0]` != 0, `fetch_misalign_o` pulses high in the following cycle.
  - REQ: stay in REQ. The address changes the next cycle. If gnt arrives in the same cycle as the redirect, set the drop flag and go to WAIT.
  - WAIT: set the drop flag and stay in WAIT. The response, when it arrives, is discarded, the drop flag clears, and the FSM goes to REQ.
  - WAIT with rvalid in the same cycle: discard the data and go to REQ.
  - HOLD: the held instruction is invalidated and the FSM goes to REQ. If ready was also high that cycle, the instruction counts as consumed. Either way the next PC is the target, not PC+4.
  - Redirect while the drop flag is already set: PC updates to the newest target, and only one response is dropped.
- `imem_rvalid_i` outside WAIT is ignored. This covers stale responses after reset.
- `inst_o`/`pc_o` change only on capture in WAIT.

## Timing
- Reset values:
  - `imem_req_o`=0, `imem_addr_o`=RESET_PC
  - `inst_valid_o`=0, `inst_o`=32'h0, `pc_o`=RESET_PC
  - `fetch_misalign_o`=0
  - state=IDLE, drop flag=0
- Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- Minimum latency:
  - reset release → first `imem_req_o`: 1 cycle.
  - gnt → rvalid: ≥1 cycle (memory guarantee).
  - rvalid → `inst_valid_o`: 1 cycle (registered).
- Steady-state throughput with gnt immediate and rvalid 1 cycle after gnt: one instruction per 3 cycles (REQ, WAIT, HOLD).
- `inst_valid_o` falls in the cycle after the handshake or redirect. `inst_o`/`pc_o` are stable while `inst_valid_o`=1.
- All outputs are registered or are decoded from registered state, with no combinational path from any input to any output.

## Test plan
- **Reset and first fetch.** Release rst with gnt tied 1 and rvalid 1 cycle after gnt with rdata=32'h00000413; ready=1.
  - Required: cycle 1 req=1, addr=80000000.
  - Required: `inst_valid_o` with inst=00000413, pc=80000000.
  - Required: next request addr=80000004.
- **Backpressure.** Hold ready=0 for 5 cycles in HOLD.
  - Required: `inst_valid_o`, `inst_o` and `pc_o` stay constant, and req stays 0.
  - Required: after ready=1, the next addr is PC+4.
- **Redirect in WAIT.** Jump to 80000100 while waiting; the response arrives 2 cycles later with rdata=DEADBEEF.
  - Required: DEADBEEF is never presented.
  - Required: next req addr=80000100, and the instruction shown has pc=80000100.
- **Redirect in HOLD with ready=1 in the same cycle.**
  - Required: the next fetch addr is the target, not PC+4.
  - Required: `inst_valid_o`=0 the following cycle.
- **Misaligned target 80000102.**
  - Required: `fetch_misalign_o` is a 1-cycle pulse.
  - Required: next req addr=80000100.
- **Async reset mid-WAIT, followed by a late rvalid.**
  - Required: outputs return to reset values without a clock edge.
  - Required: the stale rvalid is ignored.
  - Required: the fetch restarts at 80000000.
